// File: rtl/cache_fill_fsm.sv
// Miss fill controller: fetches the 8-word block holding a missed address and
// steers each returned word into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int SET_W  = 7,
  parameter int WORD_W = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_detected,
  input  logic [ADDR_W-1:0]               miss_address,
  input  logic                            memory_data_valid,
  output logic                            fsm_busy,
  output logic                            mem_read_en,
  output logic [ADDR_W-1:0]               memory_address,
  output logic [SET_W-1:0]                fill_set,
  output logic [WORD_W-1:0]               fill_word,
  output logic                            write_data_array,
  output logic                            write_tag_array,
  output logic [ADDR_W-SET_W-WORD_W-2:0]  fill_tag
);

  localparam int OFS_W = WORD_W + 1;
  localparam logic [WORD_W:0]   LAST_WORD = {1'b0, {WORD_W{1'b1}}};
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'((1 << OFS_W) - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_next;
  logic [WORD_W:0]   issue_cnt, recv_cnt;
  logic [ADDR_W-1:0] base;
  logic [WORD_W-1:0] issue_idx;
  logic [ADDR_W-1:0] word_ofs;
  logic              done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (miss_detected) begin
          base      <= miss_address & BLK_MASK;
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
      end else begin
        if (!issue_cnt[WORD_W])
          issue_cnt <= issue_cnt + 1'b1;
        if (memory_data_valid && !recv_cnt[WORD_W])
          recv_cnt <= recv_cnt + 1'b1;
      end
    end
  end

  // Counters saturate at 8; index views clamp to 7 so the last request address
  // and the last written word index stay on display after the block completes.
  always_comb begin
    issue_idx = issue_cnt[WORD_W] ? '1 : issue_cnt[WORD_W-1:0];
    fill_word = recv_cnt[WORD_W]  ? '1 : recv_cnt[WORD_W-1:0];
    word_ofs  = '0;
    word_ofs[WORD_W:0] = {issue_idx, 1'b0};
    memory_address = base + word_ofs;
    fill_set = base[SET_W+WORD_W:OFS_W];
    fill_tag = base[ADDR_W-1:SET_W+OFS_W];
  end

  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected)
          state_next = FILL;
      end
      FILL: begin
        // Strobes are suppressed during the reset cycle itself.
        fsm_busy         = !rst;
        mem_read_en      = !rst && !issue_cnt[WORD_W];
        write_data_array = !rst && memory_data_valid;
        done             = memory_data_valid && (recv_cnt == LAST_WORD);
        write_tag_array  = !rst && done;
        if (done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: stimulus queues expected reads, writes and
// busy spans; a negedge monitor pops and compares whenever the DUT strobes.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic [6:0]  fill_set;
  logic [2:0]  fill_word;
  logic        write_data_array;
  logic        write_tag_array;
  logic [4:0]  fill_tag;

  logic [3:0]  pipe = '0;
  logic        stray = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [15:0] addr_q[$];
  logic [16:0] wr_q[$];
  int          busy_q[$];
  int          busy_run = 0;

  cache_fill_fsm #(.ADDR_W(16), .SET_W(7), .WORD_W(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .fill_set          (fill_set),
    .fill_word         (fill_word),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_tag          (fill_tag)
  );

  always #5 clk = ~clk;

  // Memory with fixed 4-cycle read latency, flushed by reset.
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[2:0], mem_read_en};
  end
  assign memory_data_valid = pipe[3] | stray;

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [16:0] ew;
    if (mem_read_en) begin
      total++;
      if (addr_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got addr=%h, required no read", memory_address);
      end else begin
        ea = addr_q.pop_front();
        if (memory_address !== ea) begin
          bad++;
          $display("FAIL rd_addr: got %h, required %h", memory_address, ea);
        end
      end
    end
    if (write_data_array || write_tag_array) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got wd=%b wt=%b word=%0d, required no write",
                 write_data_array, write_tag_array, fill_word);
      end else begin
        ew = wr_q.pop_front();
        if ({write_data_array, write_tag_array, fill_set, fill_word, fill_tag} !== ew) begin
          bad++;
          $display("FAIL wr_entry: got wd=%b wt=%b set=%h word=%0d tag=%h, required wd=%b wt=%b set=%h word=%0d tag=%h",
                   write_data_array, write_tag_array, fill_set, fill_word, fill_tag,
                   ew[16], ew[15], ew[14:8], ew[7:5], ew[4:0]);
        end
      end
    end
    if (fsm_busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      total++;
      if (busy_q.size() == 0) begin
        bad++;
        $display("FAIL busy_unexpected: got run=%0d, required none", busy_run);
      end else if (busy_run != busy_q[0]) begin
        bad++;
        $display("FAIL busy_len: got %0d, required %0d", busy_run, busy_q[0]);
        void'(busy_q.pop_front());
      end else begin
        void'(busy_q.pop_front());
      end
      busy_run = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectation for one miss: n_rd reads, n_wr word writes.
  task automatic expect_fill(input logic [15:0] base, input logic [6:0] set,
                             input logic [4:0] tag, input int n_rd, input int n_wr,
                             input int busy_len);
    for (int i = 0; i < n_rd; i++)
      addr_q.push_back(base + 16'(2 * i));
    for (int i = 0; i < n_wr; i++)
      wr_q.push_back({1'b1, (i == 7), set, 3'(i), tag});
    busy_q.push_back(busy_len);
  endtask

  task automatic pulse_miss(input logic [15:0] a);
    miss_detected = 1'b1;
    miss_address  = a;
    cyc();
    miss_detected = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (fsm_busy && n < 60) begin
      cyc();
      n++;
    end
    if (fsm_busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b1;
    miss_address  = 16'h5678;

    // Reset held two cycles with a miss pending: everything stays quiet.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({fsm_busy, mem_read_en, write_data_array, write_tag_array,
           memory_address, fill_set, fill_word, fill_tag} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got busy=%b rd=%b wd=%b wt=%b addr=%h set=%h word=%0d tag=%h, required all 0",
                 fsm_busy, mem_read_en, write_data_array, write_tag_array,
                 memory_address, fill_set, fill_word, fill_tag);
      end
    end
    cyc();
    rst = 1'b0;
    miss_detected = 1'b0;
    cyc();

    // Basic fill with a spurious mid-fill miss at another address.
    expect_fill(16'h1230, 7'h23, 5'h02, 8, 8, 12);
    pulse_miss(16'h1234);
    repeat (3) cyc();
    pulse_miss(16'h8888);
    wait_idle("fill1");

    // Stray data valid while idle must not write.
    cyc();
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    cyc();

    // Top-of-memory block, then a back-to-back miss the cycle busy drops.
    expect_fill(16'hFFF0, 7'h7F, 5'h1F, 8, 8, 12);
    pulse_miss(16'hFFFF);
    wait_idle("fill_top");
    expect_fill(16'h0A50, 7'h25, 5'h01, 8, 8, 12);
    pulse_miss(16'h0A5C);
    wait_idle("fill_b2b");
    cyc();

    // Reset after three returned words: seven reads issued, no tag write.
    expect_fill(16'h4320, 7'h32, 5'h08, 7, 3, 7);
    pulse_miss(16'h4321);
    repeat (7) cyc();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({write_data_array, write_tag_array, fsm_busy} !== 3'b000) begin
      bad++;
      $display("FAIL rst_midfill: got wd=%b wt=%b busy=%b, required 0 0 0",
               write_data_array, write_tag_array, fsm_busy);
    end
    cyc();
    rst = 1'b0;
    cyc();

    // Full fill after the aborted one.
    expect_fill(16'h2000, 7'h00, 5'h04, 8, 8, 12);
    pulse_miss(16'h2006);
    wait_idle("fill_after_rst");
    repeat (6) cyc();

    total++;
    if (addr_q.size() != 0 || wr_q.size() != 0 || busy_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got rd=%0d wr=%0d busy=%0d pending, required 0 0 0",
               addr_q.size(), wr_q.size(), busy_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
